ecm_frame_rx: RTL
=================

# ecm_frame_rx

Byte-stream frame parser for the ECM UART link. It sits between `UARTrx` (`data`, `data_valid`) and the ladder/result logic. It hunts for the sync header 05 05 0A 0A, reads a 16-bit big-endian payload length in bits, and assembles the payload bytes into a right-aligned register. It is the receive-side counterpart of the result frame that the ECM top transmits: sync, length 512, X[255:0], Z[255:0], all MSB-first.

## Interface
- PAYLOAD_BITS, 512, payload register width; multiple of 8, ≤ 65528
- TIMEOUT_CYCLES, 50000, maximum idle sys_clk cycles between bytes inside a frame (1 ms at 50 MHz)

- sys_clk  in  1  system clock
- sys_rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  byte from UARTrx
- rx_valid  in  1  one-cycle strobe; rx_data is valid while it is high
- payload  out  PAYLOAD_BITS  last good payload, right-aligned; first received byte is most significant
- payload_len  out  16  bit length of the last good frame
- frame_valid  out  1  one-cycle pulse when payload/payload_len update
- frame_err  out  1  one-cycle pulse on a rejected frame
- err_code  out  2  cause of the last error: 0 none, 1 bad length, 2 timeout; held until next frame_valid (clears to 0) or next frame_err
- busy  out  1  high while the parser is not in S_HUNT with sync index 0

## Operation
- States: S_HUNT (with sync index 0..3), S_LEN_HI, S_LEN_LO, S_PAYLOAD.
- Each state and counter update happens only on cycles where rx_valid=1, except timeout handling.
- S_HUNT sync rule for expected sequence 05 05 0A 0A:
  - A byte matching the expected header byte at the current index advances the index. Index 3 plus a match goes to S_LEN_HI.
  - Mismatch at index 2 with byte 05: index stays 2.
  - Mismatch at index 3 with byte 05: index becomes 1.
  - Any other mismatch: index 0, or index 1 if the byte is 05.
- S_LEN_HI: latch len[15:8], go to S_LEN_LO.
- S_LEN_LO: form len = {len_hi, byte}.
  - len is valid when len≠0, len[2:0]==0 and len≤PAYLOAD_BITS.
  - Valid: byte counter = len>>3, shadow register cleared to 0, go to S_PAYLOAD.
  - Invalid: frame_err, err_code=1, go to S_HUNT index 0.
- S_PAYLOAD, per byte: shadow <= {shadow[PAYLOAD_BITS-9:0], rx_data}, counter decrements. On the byte that takes the counter 1→0:
  - payload <= next shadow value
  - payload_len <= len
  - frame_valid pulse, err_code <= 0
  - go to S_HUNT index 0
- The shadow register is internal. payload changes only on frame_valid and is unaffected by errors.
- Timeout: an idle counter clears on every rx_valid and counts while busy=1.
  - If it reaches TIMEOUT_CYCLES-1 on a cycle with rx_valid=0: frame_err, err_code=2, go to S_HUNT index 0.
  - If rx_valid coincides with expiry, the byte wins: it is processed normally and the counter clears.
- With len=512 the frame decodes as X = payload[511:256], Z = payload[255:0].

## Timing
- Reset values: payload=0, payload_len=0, frame_valid=0, frame_err=0, err_code=0, busy=0, state S_HUNT index 0, counters 0.
- An asserted reset mid-frame discards the partial frame and leaves no pulse.
- frame_valid and frame_err are registered. They are high for exactly the one cycle after the rx_valid cycle (or the timeout cycle) that triggers them.
- payload and payload_len change on the same edge that raises frame_valid.
- busy rises the cycle after the first accepted 05 and falls with the frame_valid/frame_err edge.
- Back-to-back frames: the parser is ready for a new header byte on the cycle frame_valid is high. No byte is dropped even if rx_valid strobes on consecutive cycles.
- The block has no backpressure, and rx_valid is never ignored.

## Test plan
- Reference frame: 05 05 0A 0A 02 00, then 32 bytes of X=…0002, then 32 bytes of Z=…0001, bytes 4340 cycles apart -> one frame_valid; payload[511:256]=2, payload[255:0]=1, payload_len=512, err_code=0.
- Resync: bytes 05 05 05 0A 0A 00 08 AB -> frame_valid; payload=0x…AB (upper bits 0), payload_len=8.
- Bad length: header then 00 07 -> frame_err, err_code=1; a valid 8-bit frame sent next is accepted. Repeat with 02 08 (520 > 512) -> err_code=1.
- Timeout: header, 00 10, AA, then silence -> frame_err exactly TIMEOUT_CYCLES cycles after the AA strobe, err_code=2, payload unchanged. A new byte arriving on the expiry cycle -> no error.
- Reset during S_PAYLOAD -> all outputs return to reset values and no pulse is emitted; a full frame afterwards decodes correctly.
- Two valid frames back-to-back with rx_valid on consecutive cycles -> two frame_valid pulses, each with the correct payload.

Source files
------------

// File: rtl/ecm_frame_rx.sv
// ============================================================================
// Module   : ecm_frame_rx
// Purpose  : ECM UART frame parser. Finds the 05 05 0A 0A sync header, reads
//            a 16-bit bit-length and assembles a right-aligned payload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecm_frame_rx #(
  parameter int PAYLOAD_BITS   = 512,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [PAYLOAD_BITS-1:0] payload,
  output logic [15:0]             payload_len,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic [1:0]              err_code,
  output logic                    busy
);

  localparam int          IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [15:0] MAX_LEN   = 16'(PAYLOAD_BITS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  ERR_NONE  = 2'd0;
  localparam logic [1:0]  ERR_LEN   = 2'd1;
  localparam logic [1:0]  ERR_TMO   = 2'd2;
  localparam logic [7:0]  SYNC_A    = 8'h05;
  localparam logic [7:0]  SYNC_B    = 8'h0A;

  typedef enum logic [1:0] {S_HUNT, S_LEN_HI, S_LEN_LO, S_PAYLOAD} state_t;

  state_t                  state_q,       state_d;
  logic [1:0]              sync_idx_q,    sync_idx_d;
  logic [15:0]             len_q,         len_d;
  logic [12:0]             cnt_q,         cnt_d;
  logic [IDLE_W-1:0]       idle_q,        idle_d;
  logic [PAYLOAD_BITS-1:0] shadow_q,      shadow_d;
  logic [PAYLOAD_BITS-1:0] payload_q,     payload_d;
  logic [15:0]             payload_len_q, payload_len_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    frame_err_q,   frame_err_d;
  logic [1:0]              err_code_q,    err_code_d;
  logic                    busy_q,        busy_d;

  logic [7:0]  exp_byte;
  logic [15:0] len_full;
  logic        len_ok;

  always_comb begin
    exp_byte = (sync_idx_q[1]) ? SYNC_B : SYNC_A;
    len_full = {len_q[15:8], rx_data};
    len_ok   = (len_full != 16'd0) && (len_full[2:0] == 3'd0) && (len_full <= MAX_LEN);

    state_d       = state_q;
    sync_idx_d    = sync_idx_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    payload_d     = payload_q;
    payload_len_d = payload_len_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    idle_d        = '0;

    if (rx_valid) begin
      // An arriving byte always wins over a coinciding timeout.
      case (state_q)
        S_HUNT: begin
          if (rx_data == exp_byte) begin
            if (sync_idx_q == 2'd3) begin
              state_d    = S_LEN_HI;
              sync_idx_d = 2'd0;
            end else begin
              sync_idx_d = sync_idx_q + 2'd1;
            end
          end else if (sync_idx_q == 2'd2 && rx_data == SYNC_A) begin
            sync_idx_d = 2'd2;
          end else if (rx_data == SYNC_A) begin
            sync_idx_d = 2'd1;
          end else begin
            sync_idx_d = 2'd0;
          end
        end
        S_LEN_HI: begin
          len_d   = {rx_data, 8'h00};
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (len_ok) begin
            len_d    = len_full;
            cnt_d    = len_full[15:3];
            shadow_d = '0;
            state_d  = S_PAYLOAD;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_HUNT;
            sync_idx_d  = 2'd0;
          end
        end
        default: begin
          shadow_d = PAYLOAD_BITS'({shadow_q, rx_data});
          cnt_d    = cnt_q - 13'd1;
          if (cnt_q == 13'd1) begin
            payload_d     = PAYLOAD_BITS'({shadow_q, rx_data});
            payload_len_d = len_q;
            frame_valid_d = 1'b1;
            err_code_d    = ERR_NONE;
            state_d       = S_HUNT;
            sync_idx_d    = 2'd0;
          end
        end
      endcase
    end else if (busy_q) begin
      if (idle_q == IDLE_LAST) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_TMO;
        state_d     = S_HUNT;
        sync_idx_d  = 2'd0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    busy_d = !(state_d == S_HUNT && sync_idx_d == 2'd0);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= S_HUNT;
      sync_idx_q    <= 2'd0;
      len_q         <= '0;
      cnt_q         <= '0;
      idle_q        <= '0;
      shadow_q      <= '0;
      payload_q     <= '0;
      payload_len_q <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_idx_q    <= sync_idx_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      shadow_q      <= shadow_d;
      payload_q     <= payload_d;
      payload_len_q <= payload_len_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign payload     = payload_q;
  assign payload_len = payload_len_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire
